// File: rtl/fnd_scan_driver.sv
// Four-digit multiplexed 7-segment driver: accepts a 14-bit binary value, converts it to BCD
// sequentially, and scans the digits. Optional leading-zero blanking: FND_LEADING_ZERO_BLANK_EN.
module fnd_scan_driver #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [13:0] i_value,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [3:0]  o_fnd_com,
    output logic [7:0]  o_fnd_font
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

    state_t       state_reg;
    logic [13:0]  bin_reg;
    logic [15:0]  bcd_reg;
    logic [3:0]   shift_cnt_reg;
    logic [3:0]   digit_reg [0:3];

    logic [PW-1:0] presc_reg;
    logic [1:0]    index_reg;
    logic [1:0]    index_next;
    logic          scan_step;
    logic [3:0]    com_reg;
    logic [7:0]    font_reg;

    logic [15:0]  bcd_adj;
    logic [29:0]  dd_shifted;
    logic [13:0]  value_sat;
    logic [3:0]   blank;

    function automatic logic [7:0] seg_font(input logic [3:0] d);
        case (d)
            4'd0:    seg_font = 8'hC0;
            4'd1:    seg_font = 8'hF9;
            4'd2:    seg_font = 8'hA4;
            4'd3:    seg_font = 8'hB0;
            4'd4:    seg_font = 8'h99;
            4'd5:    seg_font = 8'h92;
            4'd6:    seg_font = 8'h82;
            4'd7:    seg_font = 8'hF8;
            4'd8:    seg_font = 8'h80;
            4'd9:    seg_font = 8'h90;
            default: seg_font = 8'hFF;
        endcase
    endfunction

    // Double-dabble: add 3 to any BCD nibble >= 5 before each left shift.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    assign dd_shifted = {bcd_adj, bin_reg} << 1;
    assign value_sat  = (i_value > 14'd9999) ? 14'd9999 : i_value;
    assign o_ready    = (state_reg == IDLE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg     <= IDLE;
            bin_reg       <= '0;
            bcd_reg       <= '0;
            shift_cnt_reg <= '0;
            for (int i = 0; i < 4; i++) digit_reg[i] <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_valid) begin
                        bin_reg       <= value_sat;
                        bcd_reg       <= '0;
                        shift_cnt_reg <= '0;
                        state_reg     <= CONV;
                    end
                end
                CONV: begin
                    bcd_reg       <= dd_shifted[29:14];
                    bin_reg       <= dd_shifted[13:0];
                    shift_cnt_reg <= shift_cnt_reg + 4'd1;
                    if (shift_cnt_reg == 4'd13) state_reg <= UPDATE;
                end
                UPDATE: begin
                    for (int i = 0; i < 4; i++) digit_reg[i] <= bcd_reg[i*4 +: 4];
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef FND_LEADING_ZERO_BLANK_EN
    assign blank[3] = (digit_reg[3] == 4'd0);
    assign blank[2] = blank[3] && (digit_reg[2] == 4'd0);
    assign blank[1] = blank[2] && (digit_reg[1] == 4'd0);
    assign blank[0] = 1'b0;
`else
    assign blank = 4'b0000;
`endif

    assign scan_step  = (presc_reg == PW'(SCAN_DIV - 1));
    assign index_next = scan_step ? index_reg + 2'd1 : index_reg;

    // Outputs follow the next index so com and font move together with the index itself.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            presc_reg <= '0;
            index_reg <= '0;
            com_reg   <= 4'b1110;
            font_reg  <= 8'hC0;
        end else begin
            presc_reg <= scan_step ? '0 : presc_reg + 1'b1;
            index_reg <= index_next;
            com_reg   <= ~(4'b0001 << index_next);
            font_reg  <= blank[index_next] ? 8'hFF : seg_font(digit_reg[index_next]);
        end
    end

    assign o_fnd_com  = com_reg;
    assign o_fnd_font = font_reg;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Self-checking bench for fnd_scan_driver: table vectors, hand sequences and random traffic
// checked every cycle against a digit-level reference model.
module tb_fnd_scan_driver;

    localparam int SCAN_DIV = 4;
`ifdef FND_LEADING_ZERO_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [13:0] i_value = '0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [3:0]  o_fnd_com;
    logic [7:0]  o_fnd_font;

    always #5 clk = ~clk;

    fnd_scan_driver #(.SCAN_DIV(SCAN_DIV)) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_value    (i_value),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .o_fnd_com  (o_fnd_com),
        .o_fnd_font (o_fnd_font)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: edges since reset, shown digits, pending load countdown.
    int  m_t = 0;
    int  m_digits [4] = '{0, 0, 0, 0};
    int  m_prev   [4] = '{0, 0, 0, 0};
    bit  m_pending = 1'b0;
    int  m_rem = 0;
    int  m_value = 0;
    logic [7:0] font_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                  8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    logic [7:0] seen [4];

    typedef struct {
        int          value;
        logic [31:0] fonts;   // {d3,d2,d1,d0}
        logic [3:0]  lz;      // digits that are leading zeros
    } vec_t;
    vec_t vecs [10];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0d)", name, act, exp, m_t);
        end
    endtask

    function automatic logic [7:0] model_font(input int pos);
        bit all_zero;
        all_zero = 1'b1;
        for (int j = pos; j < 4; j++) if (m_prev[j] != 0) all_zero = 1'b0;
        if (BLANK && pos > 0 && all_zero) return 8'hFF;
        return font_tab[m_prev[pos]];
    endfunction

    task automatic step(input bit rst, input bit v, input int val);
        int idx;
        logic [3:0] exp_com;
        i_reset = rst;
        i_valid = v;
        i_value = 14'(val);
        @(posedge clk);
        m_prev = m_digits;
        if (rst) begin
            m_t = 0;
            m_digits = '{0, 0, 0, 0};
            m_prev   = '{0, 0, 0, 0};
            m_pending = 1'b0;
        end else begin
            m_t++;
            if (m_pending) begin
                m_rem--;
                if (m_rem == 0) begin
                    int p = 1;
                    for (int i = 0; i < 4; i++) begin
                        m_digits[i] = (m_value / p) % 10;
                        p = p * 10;
                    end
                    m_pending = 1'b0;
                end
            end else if (v) begin
                m_pending = 1'b1;
                m_rem = 15;
                m_value = (val > 9999) ? 9999 : val;
            end
        end
        idx = (m_t / SCAN_DIV) % 4;
        exp_com = ~(4'b0001 << idx);
        #1;
        check("ready", {7'd0, o_ready}, {7'd0, !m_pending});
        check("com", {4'd0, o_fnd_com}, {4'd0, exp_com});
        check("font", o_fnd_font, model_font(idx));
    endtask

    // Run one full scan period and record the font shown at each digit position.
    task automatic capture();
        for (int p = 0; p < 4; p++) seen[p] = 8'hxx;
        for (int k = 0; k < 4 * SCAN_DIV; k++) begin
            step(1'b0, 1'b0, 0);
            for (int p = 0; p < 4; p++)
                if (o_fnd_com == ~(4'b0001 << p)) seen[p] = o_fnd_font;
        end
    endtask

    task automatic check_seen(input string name, input logic [31:0] fonts, input logic [3:0] lz);
        for (int p = 0; p < 4; p++)
            check(name, seen[p], (BLANK && lz[p]) ? 8'hFF : fonts[p*8 +: 8]);
    endtask

    initial begin
        vecs[0] = '{1234,  {8'hF9, 8'hA4, 8'hB0, 8'h99}, 4'b0000};
        vecs[1] = '{16383, {8'h90, 8'h90, 8'h90, 8'h90}, 4'b0000};
        vecs[2] = '{42,    {8'hC0, 8'hC0, 8'h99, 8'hA4}, 4'b1100};
        vecs[3] = '{0,     {8'hC0, 8'hC0, 8'hC0, 8'hC0}, 4'b1110};
        vecs[4] = '{9999,  {8'h90, 8'h90, 8'h90, 8'h90}, 4'b0000};
        vecs[5] = '{10000, {8'h90, 8'h90, 8'h90, 8'h90}, 4'b0000};
        vecs[6] = '{7,     {8'hC0, 8'hC0, 8'hC0, 8'hF8}, 4'b1110};
        vecs[7] = '{5678,  {8'h92, 8'h82, 8'hF8, 8'h80}, 4'b0000};
        vecs[8] = '{1000,  {8'hF9, 8'hC0, 8'hC0, 8'hC0}, 4'b0000};
        vecs[9] = '{305,   {8'hC0, 8'hB0, 8'hC0, 8'h92}, 4'b1000};

        // Reset held two cycles, with i_valid asserted to show reset wins.
        step(1'b1, 1'b1, 1234);
        step(1'b1, 1'b1, 1234);
        check("rst_ready", {7'd0, o_ready}, 8'd1);
        check("rst_com", {4'd0, o_fnd_com}, 8'h0E);
        check("rst_font", o_fnd_font, 8'hC0);
        for (int k = 1; k < SCAN_DIV; k++) begin
            step(1'b0, 1'b0, 0);
            check("rst_idx_hold", {4'd0, o_fnd_com}, 8'h0E);
        end
        step(1'b0, 1'b0, 0);
        check("rst_idx_step", {4'd0, o_fnd_com}, 8'h0D);

        // Table of values: accept, wait out conversion, then inspect a full scan.
        for (int n = 0; n < 10; n++) begin
            step(1'b0, 1'b1, vecs[n].value);
            for (int k = 1; k <= 14; k++) begin
                step(1'b0, 1'b0, 0);
                check("conv_busy", {7'd0, o_ready}, 8'd0);
            end
            step(1'b0, 1'b0, 0);
            check("ready_n15", {7'd0, o_ready}, 8'd1);
            step(1'b0, 1'b0, 0);
            capture();
            check_seen($sformatf("vec%0d", vecs[n].value), vecs[n].fonts, vecs[n].lz);
        end

        // Busy: 5678 offered throughout the conversion of 1234 is dropped.
        step(1'b0, 1'b1, 1234);
        for (int k = 1; k <= 14; k++) begin
            step(1'b0, 1'b1, 5678);
            check("busy_ready", {7'd0, o_ready}, 8'd0);
        end
        step(1'b0, 1'b0, 0);
        check("busy_ready_n15", {7'd0, o_ready}, 8'd1);
        for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 0);
        capture();
        check_seen("busy_1234", vecs[0].fonts, vecs[0].lz);

        // Mid-conversion reset at N+7 aborts the load.
        step(1'b0, 1'b1, 5678);
        for (int k = 1; k < 7; k++) step(1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        check("midrst_ready", {7'd0, o_ready}, 8'd1);
        for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 0);
        capture();
        check_seen("midrst_zero", vecs[3].fonts, vecs[3].lz);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            int val;
            val = int'($urandom_range(16383, 0));
            if ($urandom_range(2, 0) == 0) val = val % 100;
            step($urandom_range(199, 0) == 0, $urandom_range(3, 0) == 0, val);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fnd_scan_driver.md
FND_SCAN_DRIVER -- requirements
Module: fnd_scan_driver

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 100000, giving the number of i_clk cycles each digit is driven (legal range 2 and above).
REQ-002 SHALL provide port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL provide port i_value, input, 14 bits: unsigned binary value to display.
REQ-005 SHALL provide port i_valid, input, 1 bit: i_value is offered this cycle.
REQ-006 SHALL provide port o_ready, output, 1 bit: the block can accept a value this cycle.
REQ-007 SHALL provide port o_fnd_com, output, 4 bits: active-low digit enables; bit0 is the ones digit and bit3 is the thousands digit.
REQ-008 SHALL provide port o_fnd_font, output, 8 bits: active-low segments ordered {dp,g,f,e,d,c,b,a}.

Function
REQ-009 SHALL implement an FSM with three states: IDLE, CONV and UPDATE.
REQ-010 In IDLE, SHALL drive o_ready=1; in CONV and UPDATE, SHALL drive o_ready=0.
REQ-011 SHALL accept a value only on a cycle where i_valid=1 and o_ready=1; acceptance SHALL capture i_value and move the FSM to CONV.
REQ-012 SHALL saturate a captured value greater than 9999 to 9999.
REQ-013 SHALL, in CONV, perform binary-to-BCD conversion sequentially by double-dabble: exactly 14 cycles, one shift per cycle, then move to UPDATE.
REQ-014 SHALL, in UPDATE, load the four BCD digits into the display digit registers in a single cycle, then return to IDLE.
REQ-015 SHALL meet this latency: if a value is accepted at edge N, the display digit registers update at edge N+15 and o_ready=1 from edge N+15.
REQ-016 SHALL ignore i_valid while o_ready=0; nothing is captured and nothing is queued.
REQ-017 SHALL keep showing the previously loaded digits during CONV and UPDATE.
REQ-018 SHALL run a prescaler that counts 0..SCAN_DIV-1 and then wraps to 0; at the terminal count, the 2-bit digit index SHALL increment and wrap from 3 to 0.
REQ-019 SHALL drive o_fnd_com = ~(4'b0001 << index) and o_fnd_font = font(digit[index]), both registered, so they change on the same edge.
REQ-020 SHALL use this font table: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex); dp (bit7) SHALL always be 1 (off).
REQ-021 SHALL scan continuously and independently of the FSM; an UPDATE coinciding with a scan step SHALL use the new digits from the following edge.

Reset
REQ-022 When i_reset=1 at a clock edge, SHALL enter IDLE, clear the prescaler, index, digit registers and conversion registers, and abort any conversion in progress.
REQ-023 Reset values SHALL be: o_ready=1, o_fnd_com=4'b1110, o_fnd_font=8'hC0.
REQ-024 SHALL give reset priority over a simultaneous i_valid; no value is captured on that edge.

Configuration
REQ-025 SHALL support macro FND_LEADING_ZERO_BLANK_EN; when defined, every zero digit more significant than the highest nonzero digit SHALL output font 8'hFF while its o_fnd_com bit is still asserted in the scan.
REQ-026 The ones digit SHALL never be blanked.
REQ-027 Without FND_LEADING_ZERO_BLANK_EN, all four digits SHALL display, including leading zeros.

Verification
REQ-028 Reset scenario: hold i_reset for 2 cycles -> o_ready=1, o_fnd_com=1110, o_fnd_font=C0, and the digit index stays 0 until SCAN_DIV cycles after reset release.
REQ-029 Scan scenario: SCAN_DIV=4, accept 1234 -> at edge N+15 o_ready=1; o_fnd_com then cycles 1110/1101/1011/0111, 4 clocks each, with fonts 99/B0/A4/F9.
REQ-030 Saturation scenario: accept 16383 -> all four digits show font 90 (9999).
REQ-031 Busy scenario: accept 1234, then drive i_valid with 5678 for cycles N+1..N+14 -> o_ready=0 throughout, the display ends at 1234, and o_ready=1 again at N+15.
REQ-032 Mid-conversion reset scenario: assert i_reset at edge N+7 -> o_ready=1 and all digits are 0 (font C0); no later update occurs.
REQ-033 Leading-zero scenario: accept 42 -> with FND_LEADING_ZERO_BLANK_EN, digits 3 and 2 show FF and digits 1 and 0 show 99 and A4; without the macro, digits 3 and 2 show C0.
